// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared types and helpers for the normalizer result path
package norm_pkg;

   localparam int NUM_LANES     = 4;
   localparam int PKG_DATAWIDTH = 16;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   // Lane A occupies the least significant bits, matching the FIFO word layout.
   typedef struct packed {
      logic [PKG_DATAWIDTH:0] d;
      logic [PKG_DATAWIDTH:0] c;
      logic [PKG_DATAWIDTH:0] b;
      logic [PKG_DATAWIDTH:0] a;
   } vec_t;

   function automatic logic lane_is_last(input lane_idx_t lane);
      return lane == lane_idx_t'(NUM_LANES - 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push-while-full when popping
module sync_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

endmodule

// File: rtl/norm_result_serializer.sv
// rtl/norm_result_serializer.sv - buffers divider result vectors and streams them one lane per cycle
module norm_result_serializer
   import norm_pkg::*;
#(
   parameter int DATAWIDTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_issue,
   output logic                 o_issue_ok,
   input  logic                 i_in_valid_a,
   input  logic                 i_in_valid_b,
   input  logic                 i_in_valid_c,
   input  logic                 i_in_valid_d,
   input  logic [DATAWIDTH:0]   i_in_a,
   input  logic [DATAWIDTH:0]   i_in_b,
   input  logic [DATAWIDTH:0]   i_in_c,
   input  logic [DATAWIDTH:0]   i_in_d,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [DATAWIDTH:0]   o_out_data,
   output logic [1:0]           o_out_lane,
   output logic                 o_out_last,
   output logic                 o_lane_err,
   output logic                 o_overflow_err
);

   localparam int LW = DATAWIDTH + 1;
   localparam int VW = NUM_LANES * LW;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_LANES-1:0]          w_valids;
   logic                          w_capture;
   logic                          w_lane_mismatch;
   logic [NUM_LANES-1:0][LW-1:0]  w_push_vec;
   logic [NUM_LANES-1:0][LW-1:0]  w_head;
   logic [VW-1:0]                 w_rdata;
   logic                          w_full;
   logic                          w_empty;
   logic [CW-1:0]                 w_count;
   logic [CW:0]                   w_committed;
   logic                          w_issue_acc;
   logic                          w_issue_bad;
   logic                          w_dec;
   logic                          w_orphan;
   logic                          w_accept;
   logic                          w_pop;
   logic                          w_push_ok;
   logic                          w_drop;
   logic                          w_next_nonempty;

   logic [CW-1:0]                 r_inflight;
   ser_state_t                    r_state;
   lane_idx_t                     r_lane;
   logic                          r_lane_err;
   logic                          r_overflow_err;

   // ---------------- capture and lane check ----------------
   assign w_valids        = {i_in_valid_d, i_in_valid_c, i_in_valid_b, i_in_valid_a};
   assign w_capture       = &w_valids;
   assign w_lane_mismatch = (|w_valids) && !w_capture;
   assign w_push_vec      = {i_in_d, i_in_c, i_in_b, i_in_a};

   // ---------------- credit ----------------
   // Slots already promised: vectors held in the FIFO plus vectors still inside the pipeline.
   assign w_committed = {1'b0, w_count} + {1'b0, r_inflight};
   assign o_issue_ok  = (w_committed < (CW+1)'(DEPTH));
   assign w_issue_acc = i_issue && o_issue_ok;
   assign w_issue_bad = i_issue && !o_issue_ok;
   assign w_dec       = w_capture && (r_inflight != '0);
   assign w_orphan    = w_capture && (r_inflight == '0);

   // ---------------- FIFO ----------------
   assign w_accept  = (r_state == SEND) && i_out_ready;
   assign w_pop     = w_accept && lane_is_last(r_lane);
   assign w_push_ok = w_capture && (!w_full || w_pop);
   assign w_drop    = w_capture && w_full && !w_pop;

   sync_fifo #(
      .WIDTH (VW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_capture),
      .i_wdata (w_push_vec),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Looking at the post-update occupancy lets a vector captured into an idle block appear next cycle.
   assign w_next_nonempty = w_push_ok
                         || (w_count > CW'(1))
                         || ((w_count == CW'(1)) && !w_pop);

   // In-flight counter: +1 on accepted issue, -1 on capture, saturating when credit is exhausted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue_acc, w_dec})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Sticky protocol error flags, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lane_err     <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         if (w_lane_mismatch) begin
            r_lane_err <= 1'b1;
         end
         if (w_issue_bad || w_drop || w_orphan) begin
            r_overflow_err <= 1'b1;
         end
      end
   end

   // Serializer FSM: stays in SEND while any vector remains after the current cycle's push/pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    r_state <= w_next_nonempty ? SEND : IDLE;
            SEND:    r_state <= w_next_nonempty ? SEND : IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Lane counter advances on each accepted element and wraps to A after D.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lane <= '0;
      end else if (w_accept) begin
         r_lane <= r_lane + lane_idx_t'(1);
      end
   end

   // ---------------- output stream ----------------
   // The head word is gated in IDLE so unwritten FIFO storage never reaches the bus.
   assign w_head         = w_rdata;
   assign o_out_valid    = (r_state == SEND);
   assign o_out_data     = (r_state == SEND) ? w_head[r_lane] : '0;
   assign o_out_lane     = r_lane;
   assign o_out_last     = (r_state == SEND) && lane_is_last(r_lane);
   assign o_lane_err     = r_lane_err;
   assign o_overflow_err = r_overflow_err;

endmodule

// File: tb/tb_norm_result_serializer.sv
// tb/tb_norm_result_serializer.sv - directed self-checking bench for norm_result_serializer
module tb_norm_result_serializer;
   import norm_pkg::*;

   localparam int LW    = 17;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue;
   logic          issue_ok;
   logic          va, vb, vc, vd;
   logic [LW-1:0] a, b, c, d;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] out_data;
   logic [1:0]    out_lane;
   logic          out_last;
   logic          lane_err;
   logic          overflow_err;

   int n_total = 0;
   int n_bad   = 0;

   logic [19:0] exp_q [$];

   norm_result_serializer #(.DATAWIDTH(16), .DEPTH(DEPTH)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_issue        (issue),
      .o_issue_ok     (issue_ok),
      .i_in_valid_a   (va),
      .i_in_valid_b   (vb),
      .i_in_valid_c   (vc),
      .i_in_valid_d   (vd),
      .i_in_a         (a),
      .i_in_b         (b),
      .i_in_c         (c),
      .i_in_d         (d),
      .o_out_valid    (out_valid),
      .i_out_ready    (out_ready),
      .o_out_data     (out_data),
      .o_out_lane     (out_lane),
      .o_out_last     (out_last),
      .o_lane_err     (lane_err),
      .o_overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; issue = 1'b0;
      va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic issue_one;
      issue = 1'b1; tick; issue = 1'b0;
   endtask

   task automatic capture(input vec_t v);
      a = v.a; b = v.b; c = v.c; d = v.d;
      va = 1'b1; vb = 1'b1; vc = 1'b1; vd = 1'b1;
      tick;
      va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0;
   endtask

   function automatic vec_t vec_gen(input int k);
      vec_t v;
      v.a = 17'((k << 8) | 32'h03) ^ ((k % 2 == 1) ? 17'h10000 : 17'h0);
      v.b = 17'((k << 8) | 32'h13);
      v.c = 17'((k << 8) | 32'h23) ^ 17'h08000;
      v.d = 17'((k << 8) | 32'h33) ^ ((k % 3 == 0) ? 17'h10000 : 17'h0);
      return v;
   endfunction

   function automatic logic [LW-1:0] lane_of(input vec_t v, input int l);
      case (l)
         0:       return v.a;
         1:       return v.b;
         2:       return v.c;
         default: return v.d;
      endcase
   endfunction

   function automatic logic [19:0] elem(input vec_t v, input int l);
      return {2'(l), (l == 3), lane_of(v, l)};
   endfunction

   initial begin
      logic [LW-1:0] t1_exp [4];
      vec_t v;
      int   got;
      int   waited;

      out_ready = 1'b0;
      do_reset;

      // reset values
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_lane", out_lane, 0);
      check("rst_last", out_last, 0);
      check("rst_lane_err", lane_err, 0);
      check("rst_ovf", overflow_err, 0);
      check("rst_issue_ok", issue_ok, 1);

      // single vector, consecutive lanes
      t1_exp[0] = 17'h00100; t1_exp[1] = 17'h00080; t1_exp[2] = 17'h00000; t1_exp[3] = 17'h1FFFF;
      out_ready = 1'b1;
      issue_one;
      check("t1_issue_ok_after_issue", issue_ok, 1);
      v.a = 17'h00100; v.b = 17'h00080; v.c = 17'h00000; v.d = 17'h1FFFF;
      capture(v);
      for (int l = 0; l < 4; l++) begin
         check("t1_valid", out_valid, 1);
         check("t1_lane", out_lane, 64'(l));
         check("t1_data", out_data, t1_exp[l]);
         check("t1_last", out_last, (l == 3) ? 1 : 0);
         check("t1_issue_ok", issue_ok, 1);
         tick;
      end
      check("t1_idle_after", out_valid, 0);

      // credit exhaustion
      do_reset;
      for (int i = 0; i < 4; i++) begin
         issue = 1'b1; tick;
         check("t2_issue_ok", issue_ok, (i < 3) ? 1 : 0);
      end
      issue = 1'b0;
      check("t2_no_ovf_yet", overflow_err, 0);
      issue_one;
      check("t2_ovf_fifth_issue", overflow_err, 1);
      check("t2_issue_ok_still0", issue_ok, 0);
      for (int k = 0; k < 4; k++) capture(vec_gen(k));
      for (int i = 0; i < 20; i++) tick;
      check("t2_drained_idle", out_valid, 0);
      check("t2_credit_back", issue_ok, 1);
      for (int i = 0; i < 4; i++) begin
         issue = 1'b1; tick;
         check("t2_reissue_ok", issue_ok, (i < 3) ? 1 : 0);
      end
      issue = 1'b0;

      // FIFO full with stalled output, drop of fifth capture
      do_reset;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue_one;
      for (int k = 0; k < 4; k++) capture(vec_gen(k));
      check("t3_valid_held", out_valid, 1);
      check("t3_lane_a", out_lane, 0);
      check("t3_data_a", out_data, lane_of(vec_gen(0), 0));
      check("t3_no_ovf", overflow_err, 0);
      check("t3_no_credit", issue_ok, 0);
      tick; tick;
      check("t3_stall_lane", out_lane, 0);
      check("t3_stall_data", out_data, lane_of(vec_gen(0), 0));
      capture(vec_gen(4));
      check("t3_drop_ovf", overflow_err, 1);
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (out_valid) begin
            if (got < 16) begin
               check("t3_drain_elem", {out_lane, out_last, out_data}, elem(vec_gen(got / 4), got % 4));
            end
            got++;
         end
         tick;
      end
      check("t3_drain_count", 64'(got), 16);

      // random stalls against a scoreboard
      do_reset;
      exp_q.delete();
      fork
         begin : driver
            for (int k = 0; k < 10; k++) begin
               waited = 0;
               while (!issue_ok && waited < 300) begin
                  tick;
                  waited++;
               end
               if (waited >= 300) check("t4_credit_timeout", 0, 1);
               issue_one;
               for (int l = 0; l < 4; l++) exp_q.push_back(elem(vec_gen(10 + k), l));
               capture(vec_gen(10 + k));
            end
         end
         begin : monitor
            int   recv;
            logic stalled;
            logic [19:0] snap;
            recv = 0;
            stalled = 1'b0;
            snap = '0;
            for (int cyc = 0; cyc < 3000 && recv < 40; cyc++) begin
               if (stalled) begin
                  check("t4_stall_valid", out_valid, 1);
                  check("t4_stall_stable", {out_lane, out_last, out_data}, snap);
               end
               out_ready = ($urandom_range(0, 2) != 0);
               stalled = 1'b0;
               if (out_valid) begin
                  if (out_ready) begin
                     if (exp_q.size() == 0) begin
                        check("t4_unexpected_elem", 1, 0);
                     end else begin
                        check("t4_elem", {out_lane, out_last, out_data}, exp_q.pop_front());
                     end
                     recv++;
                  end else begin
                     stalled = 1'b1;
                     snap = {out_lane, out_last, out_data};
                  end
               end
               tick;
            end
            check("t4_recv_count", 64'(recv), 40);
         end
      join
      check("t4_no_ovf", overflow_err, 0);
      check("t4_no_lane_err", lane_err, 0);

      // lane disagreement
      do_reset;
      out_ready = 1'b1;
      issue_one;
      a = 17'h05555; va = 1'b1;
      tick;
      va = 1'b0;
      check("t5_lane_err", lane_err, 1);
      check("t5_nothing_pushed", out_valid, 0);
      check("t5_no_ovf", overflow_err, 0);
      capture(vec_gen(7));
      check("t5_valid_after_good", out_valid, 1);
      check("t5_data_after_good", out_data, lane_of(vec_gen(7), 0));
      check("t5_inflight_kept", overflow_err, 0);
      for (int i = 0; i < 6; i++) tick;
      check("t5_lane_err_sticky", lane_err, 1);
      do_reset;
      check("t5_lane_err_cleared", lane_err, 0);

      // reset in the middle of a vector
      out_ready = 1'b1;
      issue_one;
      capture(vec_gen(8));
      tick; tick;
      check("t6_on_lane_c", out_lane, 2);
      rst = 1'b1;
      tick;
      check("t6_valid_cleared", out_valid, 0);
      check("t6_issue_ok", issue_ok, 1);
      rst = 1'b0;
      issue_one;
      capture(vec_gen(9));
      check("t6_new_valid", out_valid, 1);
      check("t6_new_lane0", out_lane, 0);
      check("t6_new_data", out_data, lane_of(vec_gen(9), 0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
